// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter: grants one master onto the slave port and routes
// in-order data_ok/rdata back to the issuing channel through an in-flight ID FIFO.
module sram_like_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int MAX_OUTST = 2,
    parameter int RR_MODE   = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_CH-1:0]           m_req,
    input  logic [NUM_CH-1:0]           m_wr,
    input  logic [2*NUM_CH-1:0]         m_size,
    input  logic [4*NUM_CH-1:0]         m_wstrb,
    input  logic [32*NUM_CH-1:0]        m_addr,
    input  logic [32*NUM_CH-1:0]        m_wdata,
    output logic [NUM_CH-1:0]           m_addr_ok,
    output logic [NUM_CH-1:0]           m_data_ok,
    output logic [31:0]                 m_rdata,
    output logic                        s_req,
    output logic                        s_wr,
    output logic [1:0]                  s_size,
    output logic [3:0]                  s_wstrb,
    output logic [31:0]                 s_addr,
    output logic [31:0]                 s_wdata,
    input  logic                        s_addr_ok,
    input  logic                        s_data_ok,
    input  logic [31:0]                 s_rdata,
    output logic [$clog2(MAX_OUTST):0]  outst_cnt,
    output logic                        proto_err
);
    localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(MAX_OUTST) + 1;
    localparam int IDX_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

    lock_state_e      state_q, state_d;
    logic [ID_W-1:0]  locked_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  cand;
    logic             found;

    logic [ID_W-1:0]  id_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [ID_W-1:0]  head_id;
    logic             full, empty, accept, pop;

    assign outst_cnt = wr_ptr - rd_ptr;
    assign full      = (outst_cnt == PTR_W'(MAX_OUTST));
    assign empty     = (wr_ptr == rd_ptr);
    assign wr_idx    = IDX_W'(wr_ptr % MAX_OUTST);
    assign rd_idx    = IDX_W'(rd_ptr % MAX_OUTST);
    assign head_id   = id_mem[rd_idx];

    assign s_req   = (|m_req) & ~full;
    assign accept  = s_req & s_addr_ok;
    assign pop     = s_data_ok & ~empty;
    assign m_rdata = s_rdata;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        if (state_q == ST_LOCKED) begin
            grant = locked_id;
        end else if (RR_MODE != 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cand = ID_W'((int'(rr_ptr) + k) % NUM_CH);
                if (!found && m_req[cand]) begin
                    grant = cand;
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (m_req[k]) grant = ID_W'(k);
            end
        end
    end

    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_wstrb   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s_req && grant == ID_W'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_wstrb = m_wstrb[4*i +: 4];
                s_addr  = m_addr[32*i +: 32];
                s_wdata = m_wdata[32*i +: 32];
            end
            m_addr_ok[i] = accept && (grant == ID_W'(i));
            m_data_ok[i] = pop && (head_id == ID_W'(i));
        end
    end

    // A request the slave has not yet taken pins the grant so its fields stay stable.
    always_comb begin
        state_d = state_q;
        if (accept)     state_d = ST_OPEN;
        else if (s_req) state_d = ST_LOCKED;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_OPEN;
            locked_id <= '0;
            rr_ptr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (s_req && !s_addr_ok) locked_id <= grant;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (RR_MODE != 0)
                    rr_ptr <= (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (s_data_ok && empty) proto_err <= 1'b1;
        end
    end

    // NOTE: the ID storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) id_mem[wr_idx] <= grant;
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus a random
// phase, all checked against a queue-based reference model.
module tb_sram_like_arbiter;
    localparam int N  = 2;
    localparam int D  = 2;
    localparam int CW = $clog2(D) + 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_req = '0, m_wr = '0;
    logic [2*N-1:0]  m_size = '0;
    logic [4*N-1:0]  m_wstrb = '0;
    logic [32*N-1:0] m_addr = '0, m_wdata = '0;
    logic            s_addr_ok = 1'b0, s_data_ok = 1'b0;
    logic [31:0]     s_rdata = '0;

    logic [N-1:0] m_addr_ok, m_data_ok, f_m_addr_ok, f_m_data_ok;
    logic [31:0]  m_rdata, s_addr, s_wdata, f_m_rdata, f_s_addr, f_s_wdata;
    logic         s_req, s_wr, proto_err, f_s_req, f_s_wr, f_proto_err;
    logic [1:0]   s_size, f_s_size;
    logic [3:0]   s_wstrb, f_s_wstrb;
    logic [CW-1:0] outst_cnt, f_outst_cnt;

    sram_like_arbiter #(.NUM_CH(N), .MAX_OUTST(D), .RR_MODE(1)) dut (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata), .s_req(s_req), .s_wr(s_wr),
        .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outst_cnt(outst_cnt), .proto_err(proto_err));

    sram_like_arbiter #(.NUM_CH(N), .MAX_OUTST(D), .RR_MODE(0)) u_fix (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(f_m_addr_ok),
        .m_data_ok(f_m_data_ok), .m_rdata(f_m_rdata), .s_req(f_s_req), .s_wr(f_s_wr),
        .s_size(f_s_size), .s_wstrb(f_s_wstrb), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outst_cnt(f_outst_cnt), .proto_err(f_proto_err));

    int total = 0;
    int bad   = 0;

    // Reference model: in-flight channel IDs in issue order, rotating pointer, held grant.
    int q[$];
    int rr;
    int lock_ch;
    bit perr;
    int exp_g;
    bit exp_acc, exp_pop, exp_sreq;
    logic [N-1:0] exp_aok;
    bit pend [N];

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rr      = 0;
        lock_ch = -1;
        perr    = 1'b0;
    endtask

    function automatic int model_grant();
        if (lock_ch >= 0) return lock_ch;
        for (int k = 0; k < N; k++) begin
            if (m_req[(rr + k) % N]) return (rr + k) % N;
        end
        return 0;
    endfunction

    task automatic set_ch(input int c, input bit req, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data);
        m_req[c]            = req;
        m_wr[c]             = wr;
        m_addr[32*c +: 32]  = addr;
        m_wdata[32*c +: 32] = data;
        m_size[2*c +: 2]    = 2'($urandom);
        m_wstrb[4*c +: 4]   = 4'($urandom);
    endtask

    task automatic check_cycle();
        logic [N-1:0] edok;
        logic [70:0]  efld;
        #1;
        exp_sreq = (m_req != '0) && (q.size() < D);
        exp_g    = model_grant();
        exp_acc  = exp_sreq && s_addr_ok;
        exp_pop  = s_data_ok && (q.size() > 0);
        exp_aok  = exp_acc ? (N'(1) << exp_g) : '0;
        edok     = '0;
        if (exp_pop) edok = N'(1) << q[0];
        efld = '0;
        if (exp_sreq)
            efld = {m_wr[exp_g], m_size[2*exp_g +: 2], m_wstrb[4*exp_g +: 4],
                    m_addr[32*exp_g +: 32], m_wdata[32*exp_g +: 32]};
        check("s_req", 80'(s_req), 80'(exp_sreq));
        check("m_addr_ok", 80'(m_addr_ok), 80'(exp_aok));
        check("m_data_ok", 80'(m_data_ok), 80'(edok));
        if (exp_pop) check("m_rdata", 80'(m_rdata), 80'(s_rdata));
        check("s_fields", 80'({s_wr, s_size, s_wstrb, s_addr, s_wdata}), 80'(efld));
        check("outst_cnt", 80'(outst_cnt), 80'(q.size()));
        check("proto_err", 80'(proto_err), 80'(perr));
    endtask

    task automatic advance();
        @(posedge clk);
        if (exp_pop) void'(q.pop_front());
        else if (s_data_ok) perr = 1'b1;
        if (exp_acc) begin
            q.push_back(exp_g);
            rr      = (exp_g + 1) % N;
            lock_ch = -1;
        end else if (exp_sreq) begin
            lock_ch = exp_g;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        check_cycle();
        advance();
    endtask

    logic [N-1:0] rr_seq [6];

    initial begin
        model_reset();
        rr_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        repeat (2) @(negedge clk);
        #1;
        check("rst_s_req", 80'(s_req), 80'(0));
        check("rst_outst", 80'(outst_cnt), 80'(0));
        check("rst_perr", 80'(proto_err), 80'(0));
        check("rst_aok", 80'(m_addr_ok | m_data_ok), 80'(0));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Single read from ch1: addr_ok a cycle late, data two cycles after accept.
        set_ch(1, 1'b1, 1'b0, 32'h1C00_0010, 32'h0);
        tick();
        s_addr_ok = 1'b1;
        check_cycle();
        check("single_aok", 80'(m_addr_ok), 80'(2'b10));
        advance();
        m_req = '0; s_addr_ok = 1'b0;
        tick();
        tick();
        s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
        check_cycle();
        check("single_dok", 80'(m_data_ok), 80'(2'b10));
        check("single_rdata", 80'(m_rdata), 80'(32'hDEAD_BEEF));
        advance();
        s_data_ok = 1'b0;
        tick();

        // Both channels requesting continuously; one response per cycle keeps one in flight.
        set_ch(0, 1'b1, 1'b1, 32'h0000_1000, 32'hA0A0_A0A0);
        set_ch(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
        s_addr_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data_ok = (i > 0);
            s_rdata   = $urandom;
            check_cycle();
            check("rr_grant", 80'(m_addr_ok), 80'(rr_seq[i]));
            check("fixed_grant", 80'(f_m_addr_ok), 80'(2'b01));
            advance();
        end
        m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
        tick();
        s_data_ok = 1'b0;

        // Grant held on ch1 while the slave stalls, even after ch0 raises req.
        set_ch(1, 1'b1, 1'b1, 32'h2000_0100, 32'h5555_AAAA);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_ch(0, 1'b1, 1'b0, 32'h3000_0200, 32'h0);
            check_cycle();
            check("lock_addr", 80'(s_addr), 80'(32'h2000_0100));
            advance();
        end
        s_addr_ok = 1'b1;
        tick();
        m_req[1] = 1'b0;
        check_cycle();
        check("after_lock", 80'(m_addr_ok), 80'(2'b01));
        advance();
        m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
        tick();
        tick();
        s_data_ok = 1'b0;

        // Fill the FIFO, confirm hold-off, then drain in order with a push+pop overlap.
        set_ch(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        s_addr_ok = 1'b1;
        tick();
        set_ch(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
        set_ch(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            check_cycle();
            check("full_sreq", 80'(s_req), 80'(0));
            check("full_cnt", 80'(outst_cnt), 80'(2));
            advance();
        end
        s_data_ok = 1'b1; s_rdata = 32'h11;
        check_cycle();
        check("ord_dok0", 80'(m_data_ok), 80'(2'b01));
        check("ord_rdata0", 80'(m_rdata), 80'(32'h11));
        check("full_no_push", 80'(m_addr_ok), 80'(0));
        advance();
        s_rdata = 32'h22;
        check_cycle();
        check("ord_dok1", 80'(m_data_ok), 80'(2'b10));
        check("ord_rdata1", 80'(m_rdata), 80'(32'h22));
        check("overlap_push", 80'(m_addr_ok), 80'(2'b01));
        advance();
        m_req = '0; s_addr_ok = 1'b0; s_rdata = 32'h33;
        check_cycle();
        check("overlap_cnt", 80'(outst_cnt), 80'(1));
        check("overlap_head", 80'(m_data_ok), 80'(2'b01));
        advance();
        s_data_ok = 1'b0;
        tick();

        // Random traffic: masters hold each request until their own addr_ok.
        for (int c = 0; c < N; c++) pend[c] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && ($urandom_range(0, 9) < 4)) begin
                    set_ch(c, 1'b1, 1'($urandom), $urandom, $urandom);
                    pend[c] = 1'b1;
                end
            end
            s_addr_ok = ($urandom_range(0, 1) == 1);
            s_data_ok = (q.size() > 0) && ($urandom_range(0, 9) < 6);
            s_rdata   = $urandom;
            check_cycle();
            advance();
            for (int c = 0; c < N; c++) begin
                if (exp_aok[c]) begin
                    pend[c]  = 1'b0;
                    m_req[c] = 1'b0;
                end
            end
        end
        m_req = '0; s_addr_ok = 1'b0;
        for (int i = 0; i < D; i++) begin
            s_data_ok = (q.size() > 0);
            tick();
        end

        // Stray response sets a sticky error; async reset mid-cycle clears it.
        s_data_ok = 1'b1;
        check_cycle();
        check("stray_dok", 80'(m_data_ok), 80'(0));
        advance();
        s_data_ok = 1'b0;
        set_ch(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        s_addr_ok = 1'b1;
        tick();
        m_req = '0; s_addr_ok = 1'b0;
        tick();
        #2 resetn = 1'b0;
        #1;
        check("arst_outst", 80'(outst_cnt), 80'(0));
        check("arst_perr", 80'(proto_err), 80'(0));
        check("arst_sreq", 80'(s_req), 80'(0));
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        s_data_ok = 1'b1;
        tick();
        s_data_ok = 1'b0;
        tick();
        check("late_perr", 80'(proto_err), 80'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised N-channel arbiter joining NUM_CH SRAM-like masters onto one SRAM-like slave port, using the same req/addr_ok/data_ok protocol as the core's instruction and data ports.
- Generalises the fixed inst/data pairing to any channel count, with selectable fixed-priority or round-robin arbitration.
- Tracks up to MAX_OUTST in-flight transactions so each data_ok/rdata is routed back to the channel that issued the request.
- Sits between the CPU core ports (plus future DMA/debug masters) and the shared memory or bus bridge.

Parameters:
- NUM_CH, 2, number of master channels (2..8); channel 0 is highest fixed priority.
- MAX_OUTST, 2, depth of the in-flight ID FIFO (power of 2, 1..8).
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous assert, active-low.
- m_req  in  NUM_CH  per-channel request.
- m_wr  in  NUM_CH  per-channel write flag.
- m_size  in  2*NUM_CH  per-channel size; channel i at bits [2i+1:2i].
- m_wstrb  in  4*NUM_CH  per-channel byte strobes.
- m_addr  in  32*NUM_CH  per-channel address.
- m_wdata  in  32*NUM_CH  per-channel write data.
- m_addr_ok  out  NUM_CH  one-hot request-accepted pulse.
- m_data_ok  out  NUM_CH  one-hot response pulse.
- m_rdata  out  32  read data, broadcast to all channels; valid only with the matching m_data_ok bit.
- s_req, s_wr, s_size[2], s_wstrb[4], s_addr[32], s_wdata[32]  out  slave request fields.
- s_addr_ok  in  1  slave accepts request.
- s_data_ok  in  1  slave returns response.
- s_rdata  in  32  slave read data.
- outst_cnt  out  $clog2(MAX_OUTST)+1  number of in-flight transactions.
- proto_err  out  1  sticky error flag: s_data_ok arrived with no transaction in flight.

Behaviour:
- Reset (resetn=0, async): ID FIFO empty; outst_cnt=0; rr_ptr=0; lock=0; proto_err=0. All of s_req, m_addr_ok and m_data_ok read 0.
- Grant, combinational:
  - lock=1: grant = locked_id.
  - RR_MODE=1: first requesting channel at or after rr_ptr, searching upward with wrap-around.
  - RR_MODE=0: lowest requesting index.
- s_req = |m_req & !fifo_full. The s_* fields mux the granted channel; when s_req=0 they are don't-care and are driven 0.
- Handshake: accept = s_req & s_addr_ok.
  - The same cycle pulses m_addr_ok[grant].
  - The grant ID is pushed into the FIFO.
  - RR_MODE=1: rr_ptr <= (grant+1) mod NUM_CH.
  - lock <= 0.
- Lock: s_req=1 & !s_addr_ok sets lock=1 and locked_id=grant. The grant cannot change until accept, so the slave sees stable request fields.
- Masters hold req and fields until addr_ok; this is an SRAM-like protocol requirement. A lock on a channel that drops req is illegal and not checked.
- Response: s_data_ok with FIFO non-empty pops the head ID.
  - Same cycle: m_data_ok[head]=1 and m_rdata=s_rdata, zero latency.
  - Responses are in order. Write responses are routed identically.
- s_data_ok with FIFO empty: ignored, no m_data_ok pulse, proto_err <= 1 (sticky until reset).
- Simultaneous push and pop: both happen; outst_cnt is unchanged.
  - When full, a pop in a cycle does not enable a push in that same cycle, because s_req is gated by the registered full flag.
- Full: outst_cnt == MAX_OUTST → s_req=0; m_req is held off with no m_addr_ok.
- FIFO pointers wrap modulo MAX_OUTST; an extra pointer bit distinguishes full from empty.
- Reset mid-operation clears all in-flight state immediately. Late slave responses after reset raise proto_err.

Test Plan:
- Single read, NUM_CH=2: ch1 req, addr 0x1C000010; slave addr_ok the next cycle, then data_ok 2 cycles later with 0xDEADBEEF → m_addr_ok=2'b10 for 1 cycle, then m_data_ok=2'b10, m_rdata=0xDEADBEEF; outst_cnt sequence 0,1,0.
- Round-robin, both channels continuously requesting, s_addr_ok=1 always → grants alternate 0,1,0,1. With RR_MODE=0, ch0 wins every cycle.
- Lock stability: ch1 granted, s_addr_ok held low 3 cycles while ch0 also raises req → s_addr stays ch1's address for all 3 cycles; after accept the next grant is ch0.
- Ordering and full, MAX_OUTST=2: ch0 then ch1 accepted, no data_ok yet → outst_cnt=2 and s_req=0 despite m_req=2'b11. Two data_ok with 0x11, 0x22 → m_data_ok 2'b01 with 0x11, then 2'b10 with 0x22.
- Same-cycle push and pop at outst_cnt=1 → outst_cnt stays 1 and the FIFO head advances correctly.
- Stray response: s_data_ok with FIFO empty → no m_data_ok; proto_err=1 and stays 1 until resetn is pulsed low mid-run, which clears it and outst_cnt asynchronously.
